// File: rtl/chip7458_pkg.sv
// -----------------------------------------------------------------------------
// chip7458_pkg
// Shared definitions for the chip7458 board-level tester:
//   - VEC_W / NUM_VEC : width of the stimulus vector and number of combinations
//   - state_t         : tester sequencer states
//   - P1x_BIT / P2x_BIT : position of each chip input pin inside the vector
// -----------------------------------------------------------------------------
package chip7458_pkg;

    localparam int VEC_W   = 10;
    localparam int NUM_VEC = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Section 1: three-input AND pairs feeding p1y
    localparam int P1A_BIT = 0;
    localparam int P1B_BIT = 1;
    localparam int P1C_BIT = 2;
    localparam int P1D_BIT = 3;
    localparam int P1E_BIT = 4;
    localparam int P1F_BIT = 5;

    // Section 2: two-input AND pairs feeding p2y
    localparam int P2A_BIT = 6;
    localparam int P2B_BIT = 7;
    localparam int P2C_BIT = 8;
    localparam int P2D_BIT = 9;

endpackage : chip7458_pkg

// File: rtl/chip7458_golden.sv
// -----------------------------------------------------------------------------
// chip7458_golden
// Purely combinational reference of a chip7458 (dual AND-OR gate).
//   i_vec  [9:0] : chip inputs, packed as {p2d,p2c,p2b,p2a,p1f,p1e,p1d,p1c,p1b,p1a}
//   o_gold [1:0] : expected outputs {p2y, p1y}
//                  p1y = (a&b&c) | (d&e&f), p2y = (a&b) | (c&d)
// -----------------------------------------------------------------------------
module chip7458_golden
    import chip7458_pkg::*;
(
    input  logic [VEC_W-1:0] i_vec,
    output logic [1:0]       o_gold
);

    logic w_g1;
    logic w_g2;

    assign w_g1 = (i_vec[P1A_BIT] & i_vec[P1B_BIT] & i_vec[P1C_BIT]) |
                  (i_vec[P1D_BIT] & i_vec[P1E_BIT] & i_vec[P1F_BIT]);

    assign w_g2 = (i_vec[P2A_BIT] & i_vec[P2B_BIT]) |
                  (i_vec[P2C_BIT] & i_vec[P2D_BIT]);

    assign o_gold = {w_g2, w_g1};

endmodule : chip7458_golden

// File: rtl/chip7458_tester.sv
// -----------------------------------------------------------------------------
// chip7458_tester
// Exhaustive self-checking sequencer for a chip7458 sitting beside it on the
// board. A start pulse walks all 1024 input vectors, holds each for
// SETTLE_CYCLES clocks, then compares the chip outputs with the golden model.
//
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   start               : one-cycle run request (ignored while busy)
//   abort               : stop a run in progress (ignored when idle)
//   vec     [9:0]       : vector driven onto the chip inputs
//   dut_p1y, dut_p2y    : chip outputs, only looked at in CHECK
//   busy                : run in progress (through the DONE cycle)
//   done                : one-cycle pulse when a full run completes
//   pass                : last completed run had zero mismatches
//   err_cnt [ERR_W-1:0] : mismatching vectors, saturating
//   first_fail_vec      : index of the first mismatching vector
//   first_fail_valid    : first_fail_vec holds a capture
// -----------------------------------------------------------------------------
module chip7458_tester
    import chip7458_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [VEC_W-1:0] vec,
    input  logic             dut_p1y,
    input  logic             dut_p2y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    // The settle counter only ever holds values 0..SETTLE_CYCLES-1.
    localparam int               CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(NUM_VEC - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    // r_vec doubles as the vector index: while a vector is in flight the
    // index and the pins are always equal, and vec must read 0 elsewhere.
    logic [VEC_W-1:0] r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic [ERR_W-1:0] r_err_cnt;
    logic [VEC_W-1:0] r_ff_vec;
    logic             r_ff_valid;
    logic             r_pass;

    logic [1:0]       w_gold;
    logic             w_mismatch;
    logic             w_last_vec;
    logic             w_busy;
    logic             w_done;

    chip7458_golden u_golden (
        .i_vec  (r_vec),
        .o_gold (w_gold)
    );

    // One error per vector, regardless of how many outputs disagree.
    assign w_mismatch = (dut_p1y != w_gold[0]) | (dut_p2y != w_gold[1]);
    assign w_last_vec = (r_vec == VEC_LAST);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;

        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_nxt = SETTLE;
                end
            end

            SETTLE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = CHECK;
                end
            end

            CHECK: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last_vec) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SETTLE;
                end
            end

            DONE: begin
                // The run has already completed here, so the done pulse
                // stands even if abort arrives in the same cycle.
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_busy      = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Vector, settle counter and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec      <= '0;
            r_cnt      <= '0;
            r_err_cnt  <= '0;
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Results of the previous run hold until a new start.
                    if (start) begin
                        r_vec      <= '0;
                        r_cnt      <= CNT_RELOAD;
                        r_err_cnt  <= '0;
                        r_ff_vec   <= '0;
                        r_ff_valid <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        r_vec  <= '0;
                        r_pass <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                CHECK: begin
                    // An abort in the compare cycle discards that compare;
                    // counts so far are kept as the partial result.
                    if (abort) begin
                        r_vec  <= '0;
                        r_pass <= 1'b0;
                    end else begin
                        if (w_mismatch) begin
                            if (r_err_cnt != ERR_MAX) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                            if (!r_ff_valid) begin
                                r_ff_vec   <= r_vec;
                                r_ff_valid <= 1'b1;
                            end
                        end
                        if (!w_last_vec) begin
                            r_vec <= r_vec + 1'b1;
                            r_cnt <= CNT_RELOAD;
                        end
                    end
                end

                DONE: begin
                    // err_cnt already includes the final vector's compare.
                    r_pass <= (r_err_cnt == '0);
                    r_vec  <= '0;
                end

                default: begin
                    r_vec <= '0;
                end
            endcase
        end
    end

    assign vec              = r_vec;
    assign busy             = w_busy;
    assign done             = w_done;
    assign pass             = r_pass;
    assign err_cnt          = r_err_cnt;
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_valid;

endmodule : chip7458_tester

// File: tb/tb_chip7458_tester.sv
// -----------------------------------------------------------------------------
// tb_chip7458_tester
// Two tester instances: A with default parameters, B with SETTLE_CYCLES=1 and
// ERR_W=8. Each drives a behavioural chip7458 model that can be made faulty
// (stuck outputs, random per-vector flips) or, for B, delayed by 1 or 2
// clocks. Expected results are derived from the chip truth table directly.
// -----------------------------------------------------------------------------
module tb_chip7458_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, abort_a, start_b, abort_b;
    logic [9:0]  vec_a, vec_b, ffv_a, ffv_b;
    logic        busy_a, done_a, pass_a, ffok_a;
    logic        busy_b, done_b, pass_b, ffok_b;
    logic [10:0] err_a;
    logic [7:0]  err_b;
    logic        p1_a, p2_a, p1_b, p2_b;
    logic [1:0]  dly1_b, dly2_b;

    int          mode_a = 0;
    int          mode_b = 0;
    int          lag_b  = 1;
    int          sel    = 0;
    logic [1:0]  flip [0:1023];

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_cnt, exp_first, exp_valid;

    logic [9:0]  m_vec, m_ffv;
    logic [10:0] m_err;
    logic        m_busy, m_done, m_pass, m_ffok;

    chip7458_tester u_dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_a),
        .abort            (abort_a),
        .vec              (vec_a),
        .dut_p1y          (p1_a),
        .dut_p2y          (p2_a),
        .busy             (busy_a),
        .done             (done_a),
        .pass             (pass_a),
        .err_cnt          (err_a),
        .first_fail_vec   (ffv_a),
        .first_fail_valid (ffok_a)
    );

    chip7458_tester #(
        .SETTLE_CYCLES (1),
        .ERR_W         (8)
    ) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_b),
        .abort            (abort_b),
        .vec              (vec_b),
        .dut_p1y          (p1_b),
        .dut_p2y          (p2_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .err_cnt          (err_b),
        .first_fail_vec   (ffv_b),
        .first_fail_valid (ffok_b)
    );

    assign m_vec  = (sel != 0) ? vec_b  : vec_a;
    assign m_ffv  = (sel != 0) ? ffv_b  : ffv_a;
    assign m_err  = (sel != 0) ? {3'b000, err_b} : err_a;
    assign m_busy = (sel != 0) ? busy_b : busy_a;
    assign m_done = (sel != 0) ? done_b : done_a;
    assign m_pass = (sel != 0) ? pass_b : pass_a;
    assign m_ffok = (sel != 0) ? ffok_b : ffok_a;

    // Truth table of the chip from its pin-level definition: {p2y, p1y}.
    function automatic logic [1:0] ref_out(input int i);
        bit g1, g2;
        g1 = ((i & 7) == 7) || (((i >> 3) & 7) == 7);
        g2 = (((i >> 6) & 3) == 3) || (((i >> 8) & 3) == 3);
        return {g2, g1};
    endfunction

    // Chip model: 0 good, 1 p2y stuck-0, 2 p1y stuck-1, 3 random flips.
    function automatic logic [1:0] chip_out(input int mode, input int i);
        logic [1:0] g;
        g = ref_out(i);
        case (mode)
            1:       return {1'b0, g[0]};
            2:       return {g[1], 1'b1};
            3:       return g ^ flip[i];
            default: return g;
        endcase
    endfunction

    always_comb begin
        {p2_a, p1_a} = chip_out(mode_a, {22'd0, vec_a});
    end

    always @(posedge clk) begin
        dly1_b <= chip_out(mode_b, {22'd0, vec_b});
        dly2_b <= dly1_b;
    end
    assign {p2_b, p1_b} = (lag_b == 2) ? dly2_b : dly1_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected results for the first nvec vectors. With a lag of 2 the chip
    // still shows the previous vector's response when vector i is compared
    // (vector 0 sees the idle vector, which is also 0).
    task automatic build_expect(input int mode, input int lag, input int err_w, input int nvec);
        int seen_i;
        exp_cnt   = 0;
        exp_first = 0;
        exp_valid = 0;
        for (int i = 0; i < nvec; i++) begin
            seen_i = (lag == 2 && i > 0) ? i - 1 : i;
            if (chip_out(mode, seen_i) != ref_out(i)) begin
                if (exp_cnt < (1 << err_w) - 1) exp_cnt++;
                if (exp_valid == 0) begin
                    exp_first = i;
                    exp_valid = 1;
                end
            end
        end
    endtask

    task automatic fill_flip();
        for (int i = 0; i < 1024; i++) begin
            flip[i] = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
    endtask

    task automatic drive(input logic s, input logic a);
        if (sel != 0) begin
            start_b = s;
            abort_b = a;
        end else begin
            start_a = s;
            abort_a = a;
        end
    endtask

    task automatic run_full(input string tag, input int restart_at, input bit with_abort);
        int lat;
        int c;
        bit seen;
        lat = (sel != 0) ? 2049 : 3073;
        @(negedge clk);
        drive(1'b1, with_abort);
        @(negedge clk);
        drive(1'b0, 1'b0);
        c    = 1;
        seen = 0;
        chk({tag, ".busy"}, m_busy, 1);
        while (!seen && c <= lat + 20) begin
            if (m_done) begin
                seen = 1;
            end else begin
                if (c == restart_at) drive(1'b1, 1'b0);
                @(negedge clk);
                drive(1'b0, 1'b0);
                c++;
            end
        end
        chk({tag, ".done_cycle"}, seen ? c : 0, lat);
        chk({tag, ".err_cnt"}, m_err, exp_cnt);
        chk({tag, ".ff_valid"}, m_ffok, exp_valid);
        chk({tag, ".ff_vec"}, m_ffv, exp_first);
        chk({tag, ".vec_done"}, m_vec, 1023);
        @(negedge clk);
        chk({tag, ".done_after"}, m_done, 0);
        chk({tag, ".busy_after"}, m_busy, 0);
        chk({tag, ".pass"}, m_pass, (exp_cnt == 0));
        chk({tag, ".vec_idle"}, m_vec, 0);
        repeat (4) @(negedge clk);
        chk({tag, ".err_hold"}, m_err, exp_cnt);
        chk({tag, ".pass_hold"}, m_pass, (exp_cnt == 0));
    endtask

    task automatic run_abort(input int abort_at);
        bit saw_done;
        @(negedge clk);
        drive(1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0);
        for (int c = 1; c < abort_at; c++) @(negedge clk);
        drive(1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0);
        chk("abort.busy", m_busy, 0);
        chk("abort.vec", m_vec, 0);
        chk("abort.done", m_done, 0);
        chk("abort.pass", m_pass, 0);
        chk("abort.err_cnt", m_err, exp_cnt);
        chk("abort.ff_valid", m_ffok, exp_valid);
        chk("abort.ff_vec", m_ffv, exp_first);
        saw_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (m_done) saw_done = 1;
        end
        chk("abort.no_done", saw_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst_n   = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        for (int i = 0; i < 1024; i++) flip[i] = 2'b00;
        repeat (2) @(negedge clk);

        sel = 0;
        chk("rst.vec", m_vec, 0);
        chk("rst.busy", m_busy, 0);
        chk("rst.done", m_done, 0);
        chk("rst.pass", m_pass, 0);
        chk("rst.err_cnt", m_err, 0);
        chk("rst.ff_vec", m_ffv, 0);
        chk("rst.ff_valid", m_ffok, 0);
        chk("rst.busy_b", busy_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Instance A, default parameters
        sel    = 0;
        mode_a = 0;
        build_expect(0, 1, 11, 1024);
        run_full("good", 0, 1'b0);

        mode_a = 1;
        build_expect(1, 1, 11, 1024);
        run_full("p2y_sa0", 0, 1'b0);

        mode_a = 2;
        build_expect(2, 1, 11, 1024);
        run_full("p1y_sa1", 0, 1'b0);

        mode_a = 3;
        for (int k = 0; k < 2; k++) begin
            fill_flip();
            build_expect(3, 1, 11, 1024);
            run_full("rand_flip", 0, 1'b0);
        end

        fill_flip();
        build_expect(3, 1, 11, 1024);
        run_full("restart_ignored", $urandom_range(50, 3000), 1'b0);

        mode_a = 0;
        build_expect(0, 1, 11, 1024);
        run_full("start_abort_idle", 0, 1'b1);

        mode_a = 1;
        do r = $urandom_range(700, 1500); while (r % 3 == 0);
        build_expect(1, 1, 11, r / 3);
        run_abort(r);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        drive(1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0);
        repeat ($urandom_range(600, 1200)) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.vec", m_vec, 0);
        chk("arst.busy", m_busy, 0);
        chk("arst.done", m_done, 0);
        chk("arst.pass", m_pass, 0);
        chk("arst.err_cnt", m_err, 0);
        chk("arst.ff_vec", m_ffv, 0);
        chk("arst.ff_valid", m_ffok, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mode_a = 0;
        build_expect(0, 1, 11, 1024);
        run_full("post_reset", 0, 1'b0);

        // Instance B, SETTLE_CYCLES=1, ERR_W=8
        sel    = 1;
        mode_b = 0;
        lag_b  = 1;
        build_expect(0, 1, 8, 1024);
        run_full("b_lag1", 0, 1'b0);

        lag_b = 2;
        build_expect(0, 2, 8, 1024);
        run_full("b_lag2", 0, 1'b0);
        chk("b_lag2.nonzero", (m_err != 0), 1);

        lag_b  = 1;
        mode_b = 2;
        build_expect(2, 1, 8, 1024);
        run_full("b_saturate", 0, 1'b0);

        mode_b = 3;
        fill_flip();
        build_expect(3, 1, 8, 1024);
        run_full("b_rand_flip", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_chip7458_tester
